// File: rtl/ex_issue_stage.sv
// Decode-to-execute issue register feeding the ALU: operand select, forwarding,
// load-use stall, flush and valid/ready backpressure. Optional macro: EX_FORWARD_EN.
module ex_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_rs_idx,
  input  logic [REG_AW-1:0] in_rt_idx,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr,
  input  logic              fwd_m_wr,
  input  logic [REG_AW-1:0] fwd_m_rd,
  input  logic [DATA_W-1:0] fwd_m_data,
  input  logic              fwd_m_load,
  input  logic              fwd_w_wr,
  input  logic [REG_AW-1:0] fwd_w_rd,
  input  logic [DATA_W-1:0] fwd_w_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr
);

  logic              hazard;
  logic [DATA_W-1:0] rs_res;
  logic [DATA_W-1:0] rt_res;
  logic [DATA_W-1:0] b_sel;

`ifdef EX_FORWARD_EN
  // EX/MEM wins over MEM/WB; a pending load in EX/MEM is never forwarded.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] rf,
    input logic              m_wr,
    input logic [REG_AW-1:0] m_rd,
    input logic [DATA_W-1:0] m_data,
    input logic              m_load,
    input logic              w_wr,
    input logic [REG_AW-1:0] w_rd,
    input logic [DATA_W-1:0] w_data
  );
    if (idx == '0)                              return '0;
    else if (m_wr && (m_rd == idx) && !m_load)  return m_data;
    else if (w_wr && (w_rd == idx))             return w_data;
    else                                        return rf;
  endfunction

  always_comb begin
    rs_res = resolve(in_rs_idx, in_rs_val, fwd_m_wr, fwd_m_rd, fwd_m_data, fwd_m_load,
                     fwd_w_wr, fwd_w_rd, fwd_w_data);
    rt_res = resolve(in_rt_idx, in_rt_val, fwd_m_wr, fwd_m_rd, fwd_m_data, fwd_m_load,
                     fwd_w_wr, fwd_w_rd, fwd_w_data);
    hazard = in_valid && fwd_m_wr && fwd_m_load && (fwd_m_rd != '0) &&
             ((fwd_m_rd == in_rs_idx) || (!in_use_imm && (fwd_m_rd == in_rt_idx)));
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_m_wr, fwd_m_rd, fwd_m_data, fwd_m_load,
                        fwd_w_wr, fwd_w_rd, fwd_w_data};

  always_comb begin
    rs_res = (in_rs_idx == '0) ? '0 : in_rs_val;
    rt_res = (in_rt_idx == '0) ? '0 : in_rt_val;
    hazard = 1'b0;
  end
`endif

  always_comb begin
    b_sel = in_use_imm ? {{(DATA_W-16){in_imm[15]}}, in_imm} : rt_res;
  end

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      alu_a     <= rs_res;
      alu_b     <= b_sel;
      alu_op    <= in_op;
      out_rd    <= in_rd;
      out_wr    <= in_wr && (in_rd != '0);
    end else if (out_ready) begin
      // Consumed with nothing new accepted (idle or load-use bubble).
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
    end
  end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- Decode-to-execute pipeline register sitting directly upstream of the 32-bit ALU; drives its A, B and 4-bit Op inputs from a registered stage.
- Selects operands from: register-file values, the sign-extended immediate, or forwarded results from the two later stages (EX/MEM, MEM/WB).
- Detects load-use hazards and stalls decode; supports flush and downstream backpressure through a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width (32 architectural registers, r0 hardwired zero).
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_op  in  OP_W  ALU opcode (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
- in_rs_idx, in_rt_idx  in  REG_AW each  source register indices.
- in_rs_val, in_rt_val  in  DATA_W each  register-file read data.
- in_imm  in  16  immediate.
- in_use_imm  in  1  B operand is the sign-extended in_imm instead of rt.
- in_rd  in  REG_AW  destination index.
- in_wr  in  1  instruction writes rd.
- fwd_m_wr, fwd_m_rd, fwd_m_data, fwd_m_load  in  1/REG_AW/DATA_W/1  EX/MEM stage result; load means data not yet valid.
- fwd_w_wr, fwd_w_rd, fwd_w_data  in  1/REG_AW/DATA_W  MEM/WB stage result.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  downstream consumes.
- alu_a, alu_b  out  DATA_W each  ALU operands.
- alu_op  out  OP_W  ALU opcode.
- out_rd  out  REG_AW; out_wr  out  1  destination passthrough.

Behaviour:
- Reset: out_valid=0, alu_a=0, alu_b=0, alu_op=0, out_rd=0, out_wr=0. in_ready follows its equation below.
- Reset asserted mid-operation discards any held instruction immediately (asynchronous reset).
- Handshake:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
  - Latency: exactly 1 cycle from transfer in to out_valid.
  - Full throughput (1 instruction per cycle) when there is no hazard and no backpressure.
- Holding: while out_valid & !out_ready, all outputs hold stable.
- Forwarding, evaluated per source s in {rs, rt}:
  - Priority 1: if fwd_m_wr & fwd_m_rd==s & s!=0 & !fwd_m_load, use fwd_m_data.
  - Priority 2: else if fwd_w_wr & fwd_w_rd==s & s!=0, use fwd_w_data.
  - Otherwise use the register-file value. Source index 0 always yields 0, regardless of the register-file value.
- Operand selection:
  - alu_a = resolved rs.
  - alu_b = in_use_imm ? {{16{in_imm[15]}}, in_imm} : resolved rt.
- Load-use hazard:
  - hazard = in_valid & fwd_m_wr & fwd_m_load & fwd_m_rd!=0 & (fwd_m_rd==in_rs_idx | (!in_use_imm & fwd_m_rd==in_rt_idx)).
  - While hazard is true: in_ready=0. If the downstream transfer completes that cycle, out_valid drops to 0 (a bubble is inserted).
- Flush:
  - Next edge: out_valid=0 and the incoming instruction is dropped.
  - Flush has priority over acceptance, hazard and hold.
  - out_wr is cleared together with out_valid.
- out_wr is only meaningful when out_valid=1; it is additionally forced to 0 when out_rd==0.
- Every arithmetic path is width-exact; no truncation except the immediate sign extension.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding and load-use hazard detection as specified above.
- Undefined:
  - Operands come only from in_rs_val/in_rt_val/in_imm; all fwd_* inputs are ignored.
  - hazard is tied to 0; the upstream scoreboard must stall instead.
  - Latency and handshake are unchanged.

Test Plan:
- Reset then ADD: rs=1 (val 5), rt=2 (val 7), op=0010, no forwarding active → next cycle out_valid=1, alu_a=5, alu_b=7, alu_op=0010.
- Dual-match priority: rs=3 with fwd_m (rd=3, 0x11) and fwd_w (rd=3, 0x22) both writing → alu_a=0x11. Repeat with fwd_m_wr=0 → alu_a=0x22.
- Register zero: rs=0 with fwd_m_rd=0, data 0xFFFF_FFFF → alu_a=0. Immediate 0x8000 with in_use_imm=1 → alu_b=0xFFFF_8000.
- Load-use: fwd_m_load=1, fwd_m_rd=4, in_rt_idx=4, in_use_imm=0 → in_ready=0 for that cycle and a bubble is inserted (out_valid=0). Next cycle with fwd_w (rd=4, 0x99) → alu_b=0x99.
- Backpressure: out_ready=0 for 3 cycles with a new in_valid pending → outputs stable, in_ready=0. out_ready=1 → the new instruction appears the following cycle.
- Flush while out_valid=1 and in_valid=1 → next cycle out_valid=0, out_wr=0, input not accepted. Asserting rst mid-hold → out_valid=0 immediately.
